// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - VGA timing generator streaming a 2x pixel-doubled frame buffer
module vga_frame_reader #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_ACT   = 0,
    parameter int RD_LATENCY = 1
) (
    input  logic        pclk,
    input  logic        rst_n,
    output logic [16:0] fb_addr,
    input  logic [11:0] fb_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_VEND = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    // One stored row feeds two displayed lines, each stored pixel two displayed pixels
    localparam logic [16:0] ROW_W    = 17'(H_ACTIVE / 2);
    localparam logic        SYNC_ON  = (SYNC_ACT != 0);
    localparam logic        SYNC_OFF = ~SYNC_ON;
    localparam int          PD       = RD_LATENCY;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [16:0]   row_base;
    logic          vis;
    logic          hs_raw;
    logic          vs_raw;
    logic          fs_raw;
    logic [PD:0]   de_pipe;
    logic [PD:0]   hs_pipe;
    logic [PD:0]   vs_pipe;
    logic [PD:0]   fs_pipe;

    assign vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_raw = (h_cnt >= H_SS && h_cnt < H_SE) ? SYNC_ON : SYNC_OFF;
    assign vs_raw = (v_cnt >= V_SS && v_cnt < V_SE) ? SYNC_ON : SYNC_OFF;
    assign fs_raw = (h_cnt == '0) && (v_cnt == '0);

    // Horizontal/vertical position counters, wrapping together at the frame end
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Incremental read address: step every second pixel, replay each row twice
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            fb_addr  <= '0;
            row_base <= '0;
        end else if (h_cnt == H_LAST && v_cnt == V_LAST) begin
            fb_addr  <= '0;
            row_base <= '0;
        end else if (vis) begin
            if (h_cnt == '0) begin
                fb_addr <= row_base;
            end else if (!h_cnt[0]) begin
                fb_addr <= fb_addr + 17'd1;
            end
            if (h_cnt == H_VEND && v_cnt[0]) begin
                row_base <= row_base + ROW_W;
            end
        end
    end

    // Delay the control signals to line up with the returning buffer data
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_pipe <= '0;
            fs_pipe <= '0;
            hs_pipe <= {(PD + 1){SYNC_OFF}};
            vs_pipe <= {(PD + 1){SYNC_OFF}};
        end else begin
            de_pipe <= {de_pipe[PD-1:0], vis};
            fs_pipe <= {fs_pipe[PD-1:0], fs_raw};
            hs_pipe <= {hs_pipe[PD-1:0], hs_raw};
            vs_pipe <= {vs_pipe[PD-1:0], vs_raw};
        end
    end

    // Output register; colour is forced black outside the visible window
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= SYNC_OFF;
            vga_vsync   <= SYNC_OFF;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= de_pipe[PD] ? fb_data[11:8] : 4'h0;
            vga_g       <= de_pipe[PD] ? fb_data[7:4]  : 4'h0;
            vga_b       <= de_pipe[PD] ? fb_data[3:0]  : 4'h0;
            vga_hsync   <= hs_pipe[PD];
            vga_vsync   <= vs_pipe[PD];
            de          <= de_pipe[PD];
            frame_start <= fs_pipe[PD];
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - directed bench for vga_frame_reader
module tb_vga_frame_reader;

    localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 2;
    localparam int S_VA = 8,  S_VFP = 1, S_VS = 2, S_VBP = 1;

    logic pclk = 1'b0;
    logic rst_n = 1'b0;
    logic force_fff = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;

    always #5 pclk = ~pclk;

    // Instance a: default timing, latency 1
    logic [16:0] a_addr;  logic [11:0] a_data;
    logic [3:0]  a_r, a_g, a_b;
    logic        a_hs, a_vs, a_de, a_fs;
    logic [16:0] ma_q = '0;
    always @(posedge pclk) ma_q <= a_addr;
    assign a_data = force_fff ? 12'hFFF : ma_q[11:0];

    vga_frame_reader #(.RD_LATENCY(1)) u_a (
        .pclk(pclk), .rst_n(rst_n), .fb_addr(a_addr), .fb_data(a_data),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .vga_hsync(a_hs),
        .vga_vsync(a_vs), .de(a_de), .frame_start(a_fs));

    // Instance b: default timing, latency 2
    logic [16:0] b_addr;  logic [11:0] b_data;
    logic [3:0]  b_r, b_g, b_b;
    logic        b_hs, b_vs, b_de, b_fs;
    logic [16:0] mb_q1 = '0, mb_q2 = '0;
    always @(posedge pclk) begin
        mb_q1 <= b_addr;
        mb_q2 <= mb_q1;
    end
    assign b_data = mb_q2[11:0];

    vga_frame_reader #(.RD_LATENCY(2)) u_b (
        .pclk(pclk), .rst_n(rst_n), .fb_addr(b_addr), .fb_data(b_data),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .vga_hsync(b_hs),
        .vga_vsync(b_vs), .de(b_de), .frame_start(b_fs));

    // Instance c: shrunken geometry so whole frames fit in a short run
    logic [16:0] c_addr;  logic [11:0] c_data;
    logic [3:0]  c_r, c_g, c_b;
    logic        c_hs, c_vs, c_de, c_fs;
    logic [16:0] mc_q = '0;
    always @(posedge pclk) mc_q <= c_addr;
    assign c_data = mc_q[11:0];

    vga_frame_reader #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .RD_LATENCY(1)) u_c (
        .pclk(pclk), .rst_n(rst_n), .fb_addr(c_addr), .fb_data(c_data),
        .vga_r(c_r), .vga_g(c_g), .vga_b(c_b), .vga_hsync(c_hs),
        .vga_vsync(c_vs), .de(c_de), .frame_start(c_fs));

    logic [15:0] a_out, b_out, c_out;
    assign a_out = {a_fs, a_de, a_hs, a_vs, a_r, a_g, a_b};
    assign b_out = {b_fs, b_de, b_hs, b_vs, b_r, b_g, b_b};
    assign c_out = {c_fs, c_de, c_hs, c_vs, c_r, c_g, c_b};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {frame_start, de, hsync, vsync, rgb} for counter index c
    function automatic logic [15:0] exp_out(input int c, input int ha, input int hfp,
                                            input int hs, input int hbp, input int va,
                                            input int vfp, input int vs, input int vbp);
        int ht, vt, h, v;
        logic d;
        logic [15:0] r;
        r = {1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        if (c >= 0) begin
            ht = ha + hfp + hs + hbp;
            vt = va + vfp + vs + vbp;
            h  = c % ht;
            v  = (c / ht) % vt;
            d  = (h < ha) && (v < va);
            r[15] = (h == 0) && (v == 0);
            r[14] = d;
            r[13] = !((h >= ha + hfp) && (h < ha + hfp + hs));
            r[12] = !((v >= va + vfp) && (v < va + vfp + vs));
            r[11:0] = d ? 12'((v / 2) * (ha / 2) + h / 2) : 12'h000;
        end
        return r;
    endfunction

    // Expected read address for counter index c, or -1 where it is don't-care
    function automatic int exp_addr(input int c, input int ha, input int ht,
                                    input int va, input int vt);
        int h, v;
        if (c < 0) return -1;
        h = c % ht;
        v = (c / ht) % vt;
        if (h >= ha || v >= va) return -1;
        return (v / 2) * (ha / 2) + h / 2;
    endfunction

    localparam int D_HT = 800, D_VT = 525;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;

    int   errs_a, errs_b, errs_c, errs_aa, errs_ca;
    int   c_de_cnt, c_hs_falls, c_hs_low, c_vs_low, c_fs_cnt, c_vs_first, c_fs_second;
    logic c_hs_prev, c_vs_prev;
    int   ea;

    initial begin
        errs_a = 0; errs_b = 0; errs_c = 0; errs_aa = 0; errs_ca = 0;
        c_de_cnt = 0; c_hs_falls = 0; c_hs_low = 0; c_vs_low = 0; c_fs_cnt = 0;
        c_vs_first = -1; c_fs_second = -1;
        c_hs_prev = 1'b1; c_vs_prev = 1'b1;

        repeat (5) @(negedge pclk);
        check("rst_rgb",   {a_r, a_g, a_b}, 12'h000);
        check("rst_de",    a_de, 1'b0);
        check("rst_hsync", a_hs, 1'b1);
        check("rst_vsync", a_vs, 1'b1);
        check("rst_addr",  a_addr, 17'd0);
        check("rst_fs",    a_fs, 1'b0);

        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 2600) begin
            @(negedge pclk);
            cyc++;
            force_fff = (cyc >= 660 && cyc < 780);
            if (a_out !== exp_out(cyc - 3, 640, 16, 96, 48, 480, 10, 2, 33)) errs_a++;
            if (b_out !== exp_out(cyc - 4, 640, 16, 96, 48, 480, 10, 2, 33)) errs_b++;
            if (c_out !== exp_out(cyc - 3, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP)) errs_c++;
            ea = exp_addr(cyc - 1, 640, D_HT, 480, D_VT);
            if (ea >= 0 && int'(a_addr) != ea) errs_aa++;
            ea = exp_addr(cyc - 1, S_HA, S_HT, S_VA, S_VT);
            if (ea >= 0 && int'(c_addr) != ea) errs_ca++;

            if (cyc >= 3 && cyc < 3 + 2 * S_HT * S_VT) begin
                if (c_de) c_de_cnt++;
                if (c_hs_prev && !c_hs) c_hs_falls++;
                if (!c_hs) c_hs_low++;
                if (!c_vs) c_vs_low++;
                if (c_vs_prev && !c_vs && c_vs_first < 0) c_vs_first = cyc;
                if (c_fs) begin
                    c_fs_cnt++;
                    if (c_fs_cnt == 2) c_fs_second = cyc;
                end
                c_hs_prev = c_hs;
                c_vs_prev = c_vs;
            end

            case (cyc)
                2:    check("de_before_latency", a_de, 1'b0);
                3: begin
                    check("first_de", a_de, 1'b1);
                    check("first_fs", a_fs, 1'b1);
                    check("b_de_lat3", b_de, 1'b0);
                end
                4: begin
                    check("b_first_de", b_de, 1'b1);
                    check("b_first_fs", b_fs, 1'b1);
                end
                6:    check("addr_x5_l0",  a_addr, 17'd2);
                184:  check("c_last_addr", c_addr, 17'd31);
                640:  check("addr_l0_end", a_addr, 17'd319);
                700: begin
                    check("blank_rgb_fff", {a_r, a_g, a_b}, 12'h000);
                    check("blank_de", a_de, 1'b0);
                end
                801:  check("addr_l1_start", a_addr, 17'd0);
                1440: check("addr_l1_end",   a_addr, 17'd319);
                1601: check("addr_l2_start", a_addr, 17'd320);
                2408: check("rgb_x5_y3",   {a_r, a_g, a_b}, 12'h142);
                2409: check("b_rgb_x5_y3", {b_r, b_g, b_b}, 12'h142);
                default: ;
            endcase
        end

        check("a_stream_errs",  errs_a, 0);
        check("b_stream_errs",  errs_b, 0);
        check("c_stream_errs",  errs_c, 0);
        check("a_addr_errs",    errs_aa, 0);
        check("c_addr_errs",    errs_ca, 0);
        check("c_de_count",     c_de_cnt, 256);
        check("c_hsync_pulses", c_hs_falls, 24);
        check("c_hsync_low",    c_hs_low, 96);
        check("c_vsync_low",    c_vs_low, 96);
        check("c_vsync_start",  c_vs_first, 219);
        check("c_fs_count",     c_fs_cnt, 2);
        check("c_frame_period", c_fs_second, 291);

        // Restart, then pull reset in the middle of a visible line
        rst_n = 1'b0;
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 130) begin
            @(negedge pclk);
            cyc++;
        end
        check("mr_pre_de",  c_de, 1'b1);
        check("mr_pre_rgb", {c_r, c_g, c_b}, 12'h013);
        rst_n = 1'b0;
        #1;
        check("mr_de",    c_de, 1'b0);
        check("mr_rgb",   {c_r, c_g, c_b}, 12'h000);
        check("mr_hsync", c_hs, 1'b1);
        check("mr_vsync", c_vs, 1'b1);
        check("mr_addr",  c_addr, 17'd0);
        check("mr_a_de",  a_de, 1'b0);
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        cyc = 0;
        repeat (5) begin
            @(negedge pclk);
            cyc++;
            case (cyc)
                1: check("mr_first_addr", c_addr, 17'd0);
                2: check("mr_fs_early", c_fs, 1'b0);
                3: begin
                    check("mr_fs", c_fs, 1'b1);
                    check("mr_de_back", c_de, 1'b1);
                end
                5: check("mr_rgb_x2", {c_r, c_g, c_b}, 12'h001);
                default: ;
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
